// File: rtl/imm_ext_pipe.sv
// Decode-stage immediate generator: builds the XLEN-wide immediate from instr[31:7] and
// presents it one cycle later behind a valid/ready handshake, optionally with a skid slot.
module imm_ext_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [7:0]       err_count
);

  logic [31:7]     ins;
  logic [XLEN-1:0] new_imm;
  logic            new_err;
  logic            accept;
  logic            pop;

  assign ins    = in_instr;
  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Signed casts sign-extend from the top bit of each concatenation up to XLEN.
  always_comb begin
    new_imm = '0;
    new_err = 1'b0;
    case (in_imm_src)
      3'b000: new_imm = XLEN'($signed(ins[31:20]));
      3'b001: new_imm = XLEN'($signed({ins[31:25], ins[11:7]}));
      3'b010: new_imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      3'b011: new_imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      3'b100: new_imm = XLEN'($signed({ins[31:12], 12'b0}));
      3'b101: new_imm = XLEN'(ins[19:15]);
      3'b110: new_imm = (XLEN == 64) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
      default: new_err = 1'b1;
    endcase
  end

  // An accept coinciding with a flush is discarded, so it is not counted either.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_count <= 8'd0;
    else if (accept && !flush && new_err && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end

  generate
    if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

      state_t          state;
      logic            rdy_q;
      logic [XLEN-1:0] skid_imm;
      logic [TAG_W-1:0] skid_tag;
      logic            skid_err;

      assign in_ready = rdy_q;

      // The output register always holds the oldest item; the skid slot only fills when
      // the output is stalled, and drains into the output on the next pop.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state     <= EMPTY;
          rdy_q     <= 1'b1;
          out_valid <= 1'b0;
          out_imm   <= '0;
          out_tag   <= '0;
          out_err   <= 1'b0;
          skid_imm  <= '0;
          skid_tag  <= '0;
          skid_err  <= 1'b0;
        end else if (flush) begin
          state     <= EMPTY;
          rdy_q     <= 1'b1;
          out_valid <= 1'b0;
        end else begin
          case (state)
            EMPTY: begin
              if (accept) begin
                out_imm   <= new_imm;
                out_tag   <= in_tag;
                out_err   <= new_err;
                out_valid <= 1'b1;
                state     <= ONE;
              end
            end
            ONE: begin
              if (accept && !pop) begin
                skid_imm <= new_imm;
                skid_tag <= in_tag;
                skid_err <= new_err;
                rdy_q    <= 1'b0;
                state    <= TWO;
              end else if (pop && !accept) begin
                out_valid <= 1'b0;
                state     <= EMPTY;
              end else if (accept && pop) begin
                out_imm <= new_imm;
                out_tag <= in_tag;
                out_err <= new_err;
              end
            end
            TWO: begin
              if (pop) begin
                out_imm <= skid_imm;
                out_tag <= skid_tag;
                out_err <= skid_err;
                rdy_q   <= 1'b1;
                state   <= ONE;
              end
            end
            default: begin
              out_valid <= 1'b0;
              rdy_q     <= 1'b1;
              state     <= EMPTY;
            end
          endcase
        end
      end
    end else begin : g_single
      assign in_ready = ~out_valid | out_ready;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          out_valid <= 1'b0;
          out_imm   <= '0;
          out_tag   <= '0;
          out_err   <= 1'b0;
        end else if (flush) begin
          out_valid <= 1'b0;
        end else if (accept) begin
          out_imm   <= new_imm;
          out_tag   <= in_tag;
          out_err   <= new_err;
          out_valid <= 1'b1;
        end else if (pop) begin
          out_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule
